// File: rtl/ahb_fir_pkg.sv
// Shared definitions for the FIR coefficient controller and its AHB-Lite slave front end.
package ahb_fir_pkg;

    localparam int DEF_AWIDTH   = 32;
    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_BIT_PREC = 16;
    localparam int DEF_TAPS     = 8;
    localparam int DEF_CNT_W    = 32;

    // Register word indices (haddr[7:2])
    localparam logic [5:0] CTRL_IDX      = 6'd0;
    localparam logic [5:0] STATUS_IDX    = 6'd1;
    localparam logic [5:0] CNT_IDX       = 6'd2;
    localparam logic [5:0] COEF_BASE_IDX = 6'd16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_SWAP       = 2'd2,
        ST_FLUSH      = 2'd3
    } coef_state_t;

    function automatic logic is_coef_idx(input logic [5:0] idx, input int taps);
        return (int'(idx) >= int'(COEF_BASE_IDX)) && (int'(idx) < int'(COEF_BASE_IDX) + taps);
    endfunction

endpackage

// File: rtl/ahb_lite_slave_if.sv
// Generic AHB-Lite slave front end: address-phase capture, decode error and the
// two-cycle ERROR response. The owning block supplies the decode and any stall.
module ahb_lite_slave_if
    import ahb_fir_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [AWIDTH-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic              addr_ok,
    input  logic              stall,
    output logic              hreadyout,
    output logic              hresp,
    output logic              dp_valid,
    output logic              dp_write,
    output logic [5:0]        dp_idx,
    output logic              dp_ok,
    output logic              dp_done
);

    // Handshake: an address phase is accepted on a clock edge where hready is high;
    // its data phase completes on the first edge where hreadyout is high. A legal
    // transfer's side effects happen only on that completing edge (dp_done).
    logic addr_phase;
    logic dp_err;
    logic err_second;
    logic unused_addr;

    assign addr_phase = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_idx     <= '0;
            dp_err     <= 1'b0;
            err_second <= 1'b0;
        end else if (hready) begin
            dp_valid   <= addr_phase;
            dp_write   <= hwrite;
            dp_idx     <= haddr[7:2];
            dp_err     <= addr_phase && (!addr_ok || hsize != HSIZE_WORD);
            err_second <= 1'b0;
        end else if (dp_valid && dp_err) begin
            err_second <= 1'b1;
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        if (dp_valid && dp_err) begin
            hreadyout = err_second;
            hresp     = 1'b1;
        end else if (dp_valid && stall) begin
            hreadyout = 1'b0;
        end
    end

    assign dp_ok   = dp_valid && !dp_err;
    assign dp_done = dp_ok && hreadyout;

    assign unused_addr = ^{haddr[AWIDTH-1:8], haddr[1:0]};

endmodule

// File: rtl/fir_coef_ctrl.sv
// FIR coefficient bank owner: shadow/active banks, commit sequencing against FIR
// sample activity, optional delay-line flush and a saturating sample counter.
module fir_coef_ctrl
    import ahb_fir_pkg::*;
#(
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int BIT_PREC = DEF_BIT_PREC,
    parameter int TAPS     = DEF_TAPS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           hsel,
    input  logic [AWIDTH-1:0]              haddr,
    input  logic [2:0]                     hsize,
    input  logic                           hwrite,
    input  logic [1:0]                     htrans,
    input  logic [DWIDTH-1:0]              hwdata,
    input  logic                           hready,
    output logic                           hreadyout,
    output logic                           hresp,
    output logic [DWIDTH-1:0]              hrdata,
    output logic [TAPS-1:0][BIT_PREC-1:0]  fircoefs,
    input  logic                           fir_sample,
    output logic                           flush_active
);

    localparam int FCW = $clog2(TAPS + 1);
    localparam logic [FCW-1:0] FLUSH_LEN = FCW'(TAPS - 1);

    coef_state_t state, state_nxt;

    logic [TAPS-1:0][BIT_PREC-1:0] shadow;
    logic [TAPS-1:0][BIT_PREC-1:0] active;
    logic [CNT_W-1:0]              sample_cnt;
    logic [FCW-1:0]                flush_cnt;
    logic                          auto_flush;
    logic                          flush_req;
    logic                          commit_pending;
    logic                          flushing;

    logic [5:0] a_idx;
    logic       addr_ok;
    logic       stall;
    logic       dp_valid, dp_write, dp_ok, dp_done;
    logic [5:0] dp_idx;
    logic       wr_en, ctrl_wr, cnt_wr;
    logic       unused_hwdata;

    assign a_idx   = haddr[7:2];
    assign addr_ok = (a_idx == CTRL_IDX) || (a_idx == STATUS_IDX) || (a_idx == CNT_IDX) ||
                     is_coef_idx(a_idx, TAPS);

    // A shadow write must not land until the pending commit has copied the old shadow
    assign stall = dp_valid && dp_write && is_coef_idx(dp_idx, TAPS) && commit_pending;

    ahb_lite_slave_if #(
        .AWIDTH (AWIDTH)
    ) u_if (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hready    (hready),
        .addr_ok   (addr_ok),
        .stall     (stall),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .dp_valid  (dp_valid),
        .dp_write  (dp_write),
        .dp_idx    (dp_idx),
        .dp_ok     (dp_ok),
        .dp_done   (dp_done)
    );

    assign wr_en   = dp_done && dp_write;
    assign ctrl_wr = wr_en && (dp_idx == CTRL_IDX);
    assign cnt_wr  = wr_en && (dp_idx == CNT_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_wr && hwdata[0])      state_nxt = ST_WAIT_QUIET;
                else if (ctrl_wr && hwdata[1]) state_nxt = ST_FLUSH;
            end
            ST_WAIT_QUIET: if (!fir_sample) state_nxt = ST_SWAP;
            ST_SWAP:       state_nxt = (auto_flush || flush_req) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH:      if (flush_cnt == FCW'(1)) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        commit_pending = (state == ST_WAIT_QUIET) || (state == ST_SWAP);
        flushing       = (state == ST_FLUSH);
        flush_active   = flushing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            flush_req <= 1'b0;
        end else begin
            if (state != ST_FLUSH && state_nxt == ST_FLUSH) flush_cnt <= FLUSH_LEN;
            else if (state == ST_FLUSH)                    flush_cnt <= flush_cnt - FCW'(1);

            if (state == ST_IDLE && ctrl_wr && hwdata[0]) flush_req <= hwdata[1];
            else if (state == ST_SWAP)                    flush_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            active     <= '0;
            auto_flush <= 1'b0;
        end else begin
            if (state == ST_SWAP) active <= shadow;
            if (ctrl_wr) auto_flush <= hwdata[2];
            for (int k = 0; k < TAPS; k++) begin
                if (wr_en && dp_idx == 6'(int'(COEF_BASE_IDX) + k))
                    shadow[k] <= hwdata[BIT_PREC-1:0];
            end
        end
    end

    // Clear wins over a simultaneous increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               sample_cnt <= '0;
        else if (cnt_wr)                          sample_cnt <= '0;
        else if (fir_sample && sample_cnt != '1)  sample_cnt <= sample_cnt + CNT_W'(1);
    end

    always_comb begin
        hrdata = '0;
        if (dp_ok && !dp_write) begin
            if (dp_idx == CTRL_IDX)   hrdata = DWIDTH'({auto_flush, 2'b00});
            if (dp_idx == STATUS_IDX) hrdata = DWIDTH'({state, flushing, commit_pending});
            if (dp_idx == CNT_IDX)    hrdata = DWIDTH'(sample_cnt);
            for (int k = 0; k < TAPS; k++) begin
                if (dp_idx == 6'(int'(COEF_BASE_IDX) + k))
                    hrdata = DWIDTH'($signed(shadow[k]));
            end
        end
    end

    assign fircoefs      = active;
    assign unused_hwdata = ^hwdata;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl with a transfer-level reference model checked every cycle.
module tb_fir_coef_ctrl;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BP   = 16;
    localparam int TAPS = 8;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic                      clk;
    logic                      rst_n;
    logic                      hsel;
    logic [AW-1:0]             haddr;
    logic [2:0]                hsize;
    logic                      hwrite;
    logic [1:0]                htrans;
    logic [DW-1:0]             hwdata;
    logic                      hready;
    logic                      hreadyout;
    logic                      hresp;
    logic [DW-1:0]             hrdata;
    logic [TAPS-1:0][BP-1:0]   fircoefs;
    logic                      fir_sample;
    logic                      flush_active;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    assign hready = hreadyout;

    fir_coef_ctrl #(
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .BIT_PREC (BP),
        .TAPS     (TAPS),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hsel         (hsel),
        .haddr        (haddr),
        .hsize        (hsize),
        .hwrite       (hwrite),
        .htrans       (htrans),
        .hwdata       (hwdata),
        .hready       (hready),
        .hreadyout    (hreadyout),
        .hresp        (hresp),
        .hrdata       (hrdata),
        .fircoefs     (fircoefs),
        .fir_sample   (fir_sample),
        .flush_active (flush_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bus transfer state, register contents and the coefficient-update mode
    // (mode 0 idle, 1 waiting for a quiet FIR, 2 swapping, 3 flushing with m_left zero samples to go)
    logic [BP-1:0] m_shadow [TAPS];
    logic [BP-1:0] m_active [TAPS];
    bit m_auto, m_flush_after, m_dp, m_dp_wr, m_dp_err;
    int m_cnt, m_mode, m_left, m_dp_idx, m_err_n;

    function automatic bit legal_idx(input int idx);
        return idx == 0 || idx == 1 || idx == 2 || (idx >= 16 && idx < 16 + TAPS);
    endfunction

    function automatic bit exp_ready();
        if (m_dp && m_dp_err) return m_err_n == 1;
        if (m_dp && m_dp_wr && m_dp_idx >= 16 && (m_mode == 1 || m_mode == 2)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!m_dp || m_dp_err || m_dp_wr) return 32'h0;
        case (m_dp_idx)
            0:       return m_auto ? 32'h4 : 32'h0;
            1:       return 32'(m_mode * 4 + (m_mode == 3 ? 2 : 0) + ((m_mode == 1 || m_mode == 2) ? 1 : 0));
            2:       return 32'(m_cnt);
            default: return 32'($signed(m_shadow[m_dp_idx - 16]));
        endcase
    endfunction

    function automatic logic [127:0] exp_coefs();
        logic [127:0] v = '0;
        for (int i = 0; i < TAPS; i++) v[i*BP +: BP] = m_active[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy, wr;
        logic [31:0] d;
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_auto = 0; m_flush_after = 0; m_dp = 0; m_dp_wr = 0; m_dp_err = 0;
            m_cnt = 0; m_mode = 0; m_left = 0; m_dp_idx = 0; m_err_n = 0;
        end else begin
            rdy = exp_ready();
            d   = hwdata;
            wr  = m_dp && !m_dp_err && rdy && m_dp_wr;
            if (wr && m_dp_idx == 2)          m_cnt = 0;
            else if (fir_sample && m_cnt < CMAX) m_cnt++;
            case (m_mode)
                0: begin
                    if (wr && m_dp_idx == 0 && d[0]) begin
                        m_mode = 1; m_flush_after = d[1];
                    end else if (wr && m_dp_idx == 0 && d[1]) begin
                        m_mode = 3; m_left = TAPS - 1;
                    end
                end
                1: if (!fir_sample) m_mode = 2;
                2: begin
                    for (int i = 0; i < TAPS; i++) m_active[i] = m_shadow[i];
                    if (m_auto || m_flush_after) begin
                        m_mode = 3; m_left = TAPS - 1;
                    end else begin
                        m_mode = 0;
                    end
                    m_flush_after = 0;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            endcase
            if (wr && m_dp_idx == 0) m_auto = d[2];
            if (wr && m_dp_idx >= 16) m_shadow[m_dp_idx - 16] = d[BP-1:0];
            if (rdy) begin
                m_dp     = hsel && htrans[1];
                m_dp_wr  = hwrite;
                m_dp_idx = int'(haddr[7:2]);
                m_dp_err = m_dp && (!legal_idx(m_dp_idx) || hsize != 3'b010);
                m_err_n  = 0;
            end else if (m_dp && m_dp_err) begin
                m_err_n++;
            end
        end
    end

    // scoreboard: every cycle out of reset, outputs against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("hreadyout", hreadyout, exp_ready());
            chk("hresp", hresp, m_dp && m_dp_err);
            chk("hrdata", hrdata, exp_rdata());
            chk("flush_active", flush_active, m_mode == 3);
            chk("fircoefs", fircoefs, exp_coefs());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit w, input int idx, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rdv, output logic rsp);
        int n = 0;
        hsel = 1'b1; htrans = 2'b10; haddr = AW'(idx) << 2; hwrite = w; hsize = sz;
        tick();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = wd;
        while (1) begin
            @(negedge clk);
            if (hreadyout) break;
            n++;
            if (n > 200) begin
                n_vec++; n_bad++;
                $display("FAIL xfer_timeout: hreadyout stuck at 0 for idx %0d", idx);
                break;
            end
            @(posedge clk);
        end
        rdv = hrdata;
        rsp = hresp;
        tick();
    endtask

    task automatic wr(input int idx, input logic [31:0] wd);
        logic [31:0] rdv;
        logic rsp;
        xfer(1'b1, idx, 3'b010, wd, rdv, rsp);
    endtask

    task automatic rd_chk(input string nm, input int idx, input logic [31:0] exp);
        logic [31:0] rdv;
        logic rsp;
        xfer(1'b0, idx, 3'b010, 32'h0, rdv, rsp);
        chk(nm, rdv, exp);
    endtask

    task automatic count_flush(output int c);
        c = 0;
        repeat (20) begin
            @(negedge clk);
            if (flush_active) c++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] rdv;
        logic rsp;
        int c;
        int lows;
        rst_n = 1'b0; hsel = 1'b0; haddr = '0; hsize = 3'b010; hwrite = 1'b0;
        htrans = 2'b00; hwdata = '0; fir_sample = 1'b0;
        repeat (3) tick();
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_flush_active", flush_active, 1'b0);
        chk("rst_fircoefs", fircoefs, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1;
        rd_chk("rst_status", 1, 32'h0);
        rd_chk("rst_cnt", 2, 32'h0);

        // first commit, quiet FIR
        for (int i = 0; i < TAPS; i++) wr(16 + i, 32'(i + 1));
        wr(0, 32'h1);
        chk("pre_swap_coefs_a", fircoefs, 128'h0);
        tick();
        chk("pre_swap_coefs_b", fircoefs, 128'h0);
        tick();
        chk("post_swap_coefs", fircoefs, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        rd_chk("status_idle", 1, 32'h0);

        // commit while the FIR is busy
        wr(16, 32'h0010);
        fir_sample = 1'b1;
        wr(0, 32'h1);
        rd_chk("status_wait_a", 1, 32'h5);
        rd_chk("status_wait_b", 1, 32'h5);
        chk("wait_coef0_old", fircoefs[0], 16'h0001);
        fir_sample = 1'b0;
        repeat (3) tick();
        chk("wait_coef0_new", fircoefs[0], 16'h0010);

        // auto flush after commit
        wr(0, 32'h4);
        rd_chk("ctrl_auto", 0, 32'h4);
        wr(17, 32'h0000_FFFE);
        wr(0, 32'h5);
        count_flush(c);
        chk("auto_flush_len", c, 7);
        chk("auto_coef1", fircoefs[1], 16'hFFFE);
        rd_chk("status_after_flush", 1, 32'h0);

        // flush only, then commit+flush together
        wr(0, 32'h2);
        count_flush(c);
        chk("flush_only_len", c, 7);
        wr(18, 32'h0123);
        wr(0, 32'h3);
        count_flush(c);
        chk("commit_flush_len", c, 7);
        chk("commit_flush_coef2", fircoefs[2], 16'h0123);

        // commit during a flush is ignored
        wr(20, 32'h0555);
        wr(0, 32'h2);
        xfer(1'b1, 0, 3'b010, 32'h1, rdv, rsp);
        chk("busy_commit_resp", rsp, 1'b0);
        repeat (12) tick();
        rd_chk("busy_commit_status", 1, 32'h0);
        chk("busy_commit_coef4", fircoefs[4], 16'h0005);

        // shadow write stalled by a pending commit
        fir_sample = 1'b1;
        wr(0, 32'h1);
        lows = 0;
        fork
            xfer(1'b1, 19, 3'b010, 32'h0000_FFFF, rdv, rsp);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (!hreadyout) lows++;
                    tick();
                end
                fir_sample = 1'b0;
            end
        join
        chk("stall_cycles", lows, 3);
        chk("stall_coef3_active", fircoefs[3], 16'h0004);
        chk("stall_coef4_swapped", fircoefs[4], 16'h0555);
        rd_chk("stall_coef3_shadow", 19, 32'hFFFF_FFFF);

        // errors
        xfer(1'b1, 40, 3'b010, 32'h1234, rdv, rsp);
        chk("err_idx40_resp", rsp, 1'b1);
        xfer(1'b1, 0, 3'b000, 32'h5, rdv, rsp);
        chk("err_byte_resp", rsp, 1'b1);
        rd_chk("err_ctrl_kept", 0, 32'h0);
        rd_chk("err_status_kept", 1, 32'h0);
        xfer(1'b0, 24, 3'b010, 32'h0, rdv, rsp);
        chk("err_idx24_resp", rsp, 1'b1);
        chk("err_idx24_data", rdv, 32'h0);
        rd_chk("last_coef", 23, 32'h8);

        // counter saturation and clear priority
        wr(2, 32'h0);
        fir_sample = 1'b1;
        repeat (70000) tick();
        fir_sample = 1'b0;
        rd_chk("cnt_saturated", 2, 32'h0000_FFFF);
        fir_sample = 1'b1;
        wr(2, 32'h1);
        fir_sample = 1'b0;
        rd_chk("cnt_clear_priority", 2, 32'h0);

        // reset mid-wait loses the commit
        fir_sample = 1'b1;
        wr(0, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_coefs", fircoefs, 128'h0);
        fir_sample = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_wait_status", 1, 32'h0);

        // reset mid-flush drops flush_active at once
        wr(0, 32'h2);
        tick();
        tick();
        chk("flush_before_rst", flush_active, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_flush_drop", flush_active, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_chk("rst_flush_status", 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
AHB-Lite slave that owns the FIR coefficient bank and sequences coefficient updates into the FIR datapath.
- Software writes a shadow bank, then commits it. The block swaps shadow into the active bank only on a cycle with no FIR sample in flight.
- Optionally flushes the FIR delay line with TAPS-1 zero samples after the swap.
- Drives the FIR coefficient input and sits on the same AHB bus segment as the FIR slave.

Parameters:
AWIDTH, 32, AHB address width (package default).
DWIDTH, 32, AHB data width (package default).
BIT_PREC, 16, coefficient width, two's complement.
TAPS, 8, number of coefficients; legal range 2..48.
CNT_W, 32, sample counter width; must be <= DWIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
hsel  in  1  AHB slave select
haddr  in  AWIDTH  AHB address
hsize  in  3  AHB transfer size
hwrite  in  1  AHB write
htrans  in  2  AHB transfer type
hwdata  in  DWIDTH  AHB write data
hready  in  1  AHB bus ready
hreadyout  out  1  slave ready
hresp  out  1  slave response (1 = ERROR)
hrdata  out  DWIDTH  read data
fircoefs  out  BIT_PREC x TAPS  active coefficient bank to FIR
fir_sample  in  1  FIR accepted a sample this cycle (FIR registered select)
flush_active  out  1  system muxes a zero sample into the FIR and strobes its enable

Behaviour:
- Reset: clk / rst_n are async, active-low. Every register clears: shadow and active banks 0, AUTO_FLUSH 0, sample count 0, FSM in IDLE. Outputs at reset: hreadyout=1, hresp=0, hrdata=0, flush_active=0, fircoefs all 0.
- AHB capture:
  - Address phase is captured when hsel & htrans[1] & hready.
  - Data phase follows one cycle later.
  - IDLE/BUSY transfers get an OKAY response with zero wait states.
- Register map (word index = haddr[7:2]):
  - 0 CTRL: bit0 COMMIT, write-1 pulse. bit1 FLUSH, write-1 pulse. bit2 AUTO_FLUSH, RW. Reads return {AUTO_FLUSH,0,0}.
  - 1 STATUS, RO: bit0 commit_pending, bit1 flushing, bits[3:2] FSM state code.
  - 2 SAMPLE_CNT: reads the count. Any write clears it.
  - 16..16+TAPS-1 COEF[i]: shadow coefficient. Writes take hwdata[BIT_PREC-1:0]. Reads return it sign-extended to DWIDTH.
- Errors: any other index, or hsize != 3'b010, gives a two-cycle ERROR.
  - Cycle 1: hreadyout=0, hresp=1. Cycle 2: hreadyout=1, hresp=1.
  - No state changes on an ERROR transfer.
- Read timing: hrdata is valid in the data phase and is 0 otherwise.
- Sample counter: increments on fir_sample, saturates at all-ones. A clear has priority over the increment in the same cycle.
- FSM states and codes: IDLE=0, WAIT_QUIET=1, SWAP=2, FLUSH=3.
  - IDLE: a COMMIT write goes to WAIT_QUIET on the next cycle and sets commit_pending. A FLUSH-only write goes to FLUSH.
  - WAIT_QUIET: stays while fir_sample=1. Goes to SWAP on the first cycle with fir_sample=0.
  - SWAP (1 cycle): active <= shadow, all TAPS atomically; commit_pending clears. Next state is FLUSH if AUTO_FLUSH is set or a FLUSH bit arrived with the commit; otherwise IDLE.
  - FLUSH: flush_active=1 for exactly TAPS-1 consecutive cycles, counted by a down-counter, then IDLE.
- fircoefs changes only at the SWAP clock edge.
- Boundary conditions:
  - COMMIT and FLUSH written together: commit, swap, then flush.
  - COMMIT or FLUSH written while not IDLE: ignored, OKAY response.
  - Shadow COEF write while commit_pending=1: wait states with hreadyout=0 until the SWAP cycle completes. The write then lands in the shadow bank and does not alter the values just swapped.
  - CTRL, STATUS and SAMPLE_CNT accesses never stall.
  - fir_sample during FLUSH is counted normally.
  - Reset asserted mid-FLUSH or mid-wait: flush_active drops immediately, asynchronously; the pending commit is lost.

Decomposition:
- Shared package (ahb_fir_pkg):
  - AWIDTH, DWIDTH, BIT_PREC and TAPS defaults.
  - Register word-index constants (CTRL_IDX, STATUS_IDX, CNT_IDX, COEF_BASE_IDX).
  - FSM state enum coef_state_t with the encodings above.
  - HTRANS and HSIZE_WORD constants.
- One sub-module: ahb_lite_slave_if, which handles address-phase capture, decode-valid/error and the two-cycle ERROR sequencing. It is reusable by other team slaves. Bank, counter and FSM stay in the top.

Test Plan:
- Reset → hreadyout=1, hresp=0, fircoefs all 0, STATUS=0, SAMPLE_CNT=0.
- Write COEF[0..7]=1..8, then CTRL=0x1 with fir_sample=0 → fircoefs unchanged until the SWAP edge two cycles after the data phase, then 1..8; STATUS returns 0.
- Hold fir_sample=1 for 5 cycles around a COMMIT → state stays WAIT_QUIET (STATUS=0x5) for those cycles; swap happens on the first quiet cycle.
- AUTO_FLUSH=1 plus COMMIT with TAPS=8 → flush_active high for exactly 7 cycles after SWAP, then STATUS=0.
- COEF[3]=0xFFFF write issued while commit_pending → hreadyout low until after SWAP. Read back 0xFFFFFFFF; the active coef[3] keeps the pre-commit shadow value.
- Access index 40 and a byte write to CTRL → two-cycle ERROR each, registers unchanged.
- 70000 fir_sample pulses with CNT_W=16 → SAMPLE_CNT saturates at 0xFFFF; a write clears it to 0.
